fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit_if_id_reg.sv | 37 +++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 108 ++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared MIPS fetch definitions: address width, NOP encoding, default reset PC
// and the next-PC selector used by fetch_unit.
package fetch_unit_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_KEEP,
    NPC_REDIR
  } npc_sel_e;

  // Clears the byte offset so a redirect always lands on a word boundary.
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: pipeline control in, instruction memory, and IF/ID outputs.
interface fetch_unit_if;
  logic                                stall;
  logic                                flush;
  logic                                branch_taken;
  logic [fetch_unit_pkg::ADDR_W-1:0]   branch_target;
  logic                                jump;
  logic [fetch_unit_pkg::ADDR_W-1:0]   jump_target;
  logic [fetch_unit_pkg::ADDR_W-1:0]   pc;
  logic [31:0]                         instr_in;
  logic [fetch_unit_pkg::ADDR_W-1:0]   if_pc;
  logic [fetch_unit_pkg::ADDR_W-1:0]   if_pc4;
  logic [31:0]                         if_instr;
  logic                                if_valid;
  logic [31:0]                         fetch_count;
  logic                                trap;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, instr_in,
    output pc, if_pc, if_pc4, if_instr, if_valid, fetch_count, trap
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, instr_in,
    input  pc, if_pc, if_pc4, if_instr, if_valid, fetch_count, trap
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble insertion, stall hold and valid-fetch counter.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              hold,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc4,
  input  logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic [31:0]       fetch_count
);
  // Bubble beats hold: a squashed slot must not survive a stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      if_pc       <= '0;
      if_pc4      <= '0;
      if_instr    <= NOP;
      if_valid    <= 1'b0;
      fetch_count <= '0;
    end else if (bubble) begin
      if_instr    <= NOP;
      if_valid    <= 1'b0;
    end else if (!hold) begin
      if_pc       <= pc;
      if_pc4      <= pc4;
      if_instr    <= instr_in;
      if_valid    <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC register, next-PC select, IF/ID register.
// Build option MISALIGN_TRAP_EN: misaligned redirects trap instead of being word-aligned.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic           clock,
  input logic           reset,
  fetch_unit_if.master  bus
);
  logic [ADDR_W-1:0] pc_q, pc_nxt, pc4, raw_tgt, tgt;
  logic              redirect, misalign, trapped, bubble;
  npc_sel_e          sel;

  assign pc4      = pc_q + 32'd4;
  assign redirect = bus.jump | bus.branch_taken;
  assign raw_tgt  = bus.jump ? bus.jump_target : bus.branch_target;

`ifdef MISALIGN_TRAP_EN
  logic trap_q;
  assign tgt      = raw_tgt;
  assign misalign = redirect && (raw_tgt[1:0] != 2'b00);
  assign trapped  = trap_q;

  // Sticky until reset: once a bad target is seen, decode only gets bubbles.
  always_ff @(posedge clock) begin
    if (reset) trap_q <= 1'b0;
    else       trap_q <= trap_q | misalign;
  end
  assign bus.trap = trap_q;
`else
  assign tgt      = align_word(raw_tgt);
  assign misalign = 1'b0;
  assign trapped  = 1'b0;
  assign bus.trap = 1'b0;
`endif

  always_comb begin
    sel = NPC_SEQ;
    if (redirect)       sel = misalign ? NPC_KEEP : NPC_REDIR;
    else if (bus.stall) sel = NPC_KEEP;
  end

  always_comb begin
    pc_nxt = pc4;
    case (sel)
      NPC_KEEP:  pc_nxt = pc_q;
      NPC_REDIR: pc_nxt = tgt;
      default:   pc_nxt = pc4;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_nxt;
  end

  assign bus.pc = pc_q;
  assign bubble = redirect | bus.flush | trapped;

  if_id_reg u_if_id (
    .clock       (clock),
    .reset       (reset),
    .bubble      (bubble),
    .hold        (bus.stall),
    .pc          (pc_q),
    .pc4         (pc4),
    .instr_in    (bus.instr_in),
    .if_pc       (bus.if_pc),
    .if_pc4      (bus.if_pc4),
    .if_instr    (bus.if_instr),
    .if_valid    (bus.if_valid),
    .fetch_count (bus.fetch_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected post-edge state,
// a monitor pops and compares on each falling edge.
module tb_fetch_unit;
  logic clock, reset;
  fetch_unit_if bus ();

  fetch_unit dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: a recognisable word per address.
  assign bus.instr_in = 32'hA000_0000 ^ bus.pc;

  typedef struct {
    string       nm;
    logic [31:0] pc, if_pc, if_pc4, if_instr, cnt;
    logic        v, trap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  function automatic void chk(string nm, string f, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s.%s actual=%h required=%h", nm, f, act, req);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "pc",          bus.pc,          e.pc);
        chk(e.nm, "if_pc",       bus.if_pc,       e.if_pc);
        chk(e.nm, "if_pc4",      bus.if_pc4,      e.if_pc4);
        chk(e.nm, "if_instr",    bus.if_instr,    e.if_instr);
        chk(e.nm, "if_valid",    {31'd0, bus.if_valid}, {31'd0, e.v});
        chk(e.nm, "fetch_count", bus.fetch_count, e.cnt);
        chk(e.nm, "trap",        {31'd0, bus.trap},     {31'd0, e.trap});
      end
    end
  end

  task automatic step(input string nm, input logic r, s, f, b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic [31:0] e_pc, e_ifpc, e_ifpc4, e_instr,
                      input logic e_v, input logic [31:0] e_cnt, input logic e_trap);
    exp_t e;
    reset = r; bus.stall = s; bus.flush = f;
    bus.branch_taken = b; bus.branch_target = bt;
    bus.jump = j; bus.jump_target = jt;
    e.nm = nm; e.pc = e_pc; e.if_pc = e_ifpc; e.if_pc4 = e_ifpc4;
    e.if_instr = e_instr; e.v = e_v; e.cnt = e_cnt; e.trap = e_trap;
    @(posedge clock);
    q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    int budget;
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus.jump = 1'b0; bus.jump_target = '0;
    @(negedge clock);
    //        name       rst s f br bt          j  jt            pc            if_pc         if_pc4        if_instr      v cnt t
    step("reset_all",    1, 1, 1, 1, 32'h40,    1, 32'h200,      32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    step("free1",        0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h4,        32'h0,        32'h4,        32'hA0000000, 1, 1, 0);
    step("free2",        0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h8,        32'h4,        32'h8,        32'hA0000004, 1, 2, 0);
    step("stall1",       0, 1, 0, 0, 32'h0,     0, 32'h0,        32'h8,        32'h4,        32'h8,        32'hA0000004, 1, 2, 0);
    step("stall2",       0, 1, 0, 0, 32'h0,     0, 32'h0,        32'h8,        32'h4,        32'h8,        32'hA0000004, 1, 2, 0);
    step("br_stall",     0, 1, 0, 1, 32'h40,    0, 32'h0,        32'h40,       32'h4,        32'h8,        32'h0,        0, 2, 0);
    step("free3",        0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h44,       32'h40,       32'h44,       32'hA0000040, 1, 3, 0);
    step("flush_stall",  0, 1, 1, 0, 32'h0,     0, 32'h0,        32'h44,       32'h40,       32'h44,       32'h0,        0, 3, 0);
    step("flush",        0, 0, 1, 0, 32'h0,     0, 32'h0,        32'h48,       32'h40,       32'h44,       32'h0,        0, 3, 0);
    step("jump_vs_br",   0, 0, 0, 1, 32'h40,    1, 32'h100,      32'h100,      32'h40,       32'h44,       32'h0,        0, 3, 0);
    step("free4",        0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h104,      32'h100,      32'h104,      32'hA0000100, 1, 4, 0);
    step("jump_top",     0, 0, 0, 0, 32'h0,     1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h100,      32'h104,      32'h0,        0, 4, 0);
    step("wrap",         0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h0,        32'h5FFFFFFC, 1, 5, 0);
    step("branch",       0, 0, 0, 1, 32'h20,    0, 32'h0,        32'h20,       32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 0);
`ifdef MISALIGN_TRAP_EN
    step("mis_jump",     0, 0, 0, 0, 32'h0,     1, 32'h102,      32'h20,       32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 1);
    step("trapped1",     0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h24,       32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 1);
    step("trapped2",     0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h28,       32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 1);
`else
    step("mis_jump",     0, 0, 0, 0, 32'h0,     1, 32'h102,      32'h100,      32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 0);
    step("after_mis1",   0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h104,      32'h100,      32'h104,      32'hA0000100, 1, 6, 0);
    step("after_mis2",   0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h108,      32'h104,      32'h108,      32'hA0000104, 1, 7, 0);
`endif
    step("reset_again",  1, 0, 0, 0, 32'h0,     0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
    step("first_fetch",  0, 0, 0, 0, 32'h0,     0, 32'h0,        32'h4,        32'h0,        32'h4,        32'hA0000000, 1, 1, 0);

    budget = 10;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    @(posedge clock);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d pending required=0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
